// File: rtl/ch9350_led_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ch9350_led_tx
//  Purpose  : Host-to-keyboard LED status frame transmitter for the CH9350 link.
//             Streams a 5-byte lock-LED frame over a valid/ready byte channel.
//  Revision : 1.0 - initial release
// ============================================================================
module ch9350_led_tx #(
    parameter int unsigned REFRESH_CYCLES = 12_000_000,
    parameter logic [7:0]  HDR0           = 8'h57,
    parameter logic [7:0]  HDR1           = 8'hAB,
    parameter logic [7:0]  CMD            = 8'h12
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [2:0] i_leds,
    input  logic       i_update,
    input  logic       i_data_ready,
    output logic       o_data_valid,
    output logic [7:0] o_data,
    output logic       o_busy
);

    localparam int unsigned          c_CNT_W   = $clog2(REFRESH_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE = c_CNT_W'(1);
    localparam logic [2:0]           c_LAST_IDX = 3'd4;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t               r_state;
    logic [2:0]           r_snapshot;
    logic [2:0]           r_idx;
    logic [c_CNT_W-1:0]   r_counter;
    logic                 r_pending;

    logic [7:0]           w_level;
    logic [7:0]           w_chk;
    logic [2:0]           w_next_idx;
    logic [7:0]           w_next_byte;
    logic                 w_trigger;
    logic                 w_accept;

    // Frame payload is derived from the snapshot, which is frozen while sending.
    assign w_level    = {5'b0, r_snapshot};
    assign w_chk      = CMD + w_level;
    assign w_next_idx = r_idx + 3'd1;
    assign w_accept   = o_data_valid & i_data_ready;
    assign w_trigger  = r_pending | i_update | (i_leds != r_snapshot) |
                        (r_counter == c_CNT_MAX);

    always_comb begin
        w_next_byte = HDR0;
        case (w_next_idx)
            3'd1:    w_next_byte = HDR1;
            3'd2:    w_next_byte = CMD;
            3'd3:    w_next_byte = w_level;
            3'd4:    w_next_byte = w_chk;
            default: w_next_byte = HDR0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_snapshot   <= 3'b000;
            r_idx        <= 3'd0;
            r_counter    <= '0;
            r_pending    <= 1'b1;
            o_data_valid <= 1'b0;
            o_data       <= 8'h00;
            o_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_snapshot   <= i_leds;
                        r_pending    <= 1'b0;
                        r_idx        <= 3'd0;
                        r_counter    <= '0;
                        r_state      <= S_SEND;
                        o_data_valid <= 1'b1;
                        o_data       <= HDR0;
                        o_busy       <= 1'b1;
                    end else begin
                        r_counter <= r_counter + c_CNT_ONE;
                    end
                end
                S_SEND: begin
                    // A request arriving mid-frame is remembered, not dropped.
                    if (i_update) begin
                        r_pending <= 1'b1;
                    end
                    if (w_accept) begin
                        if (r_idx == c_LAST_IDX) begin
                            r_state      <= S_IDLE;
                            r_idx        <= 3'd0;
                            o_data_valid <= 1'b0;
                            o_data       <= 8'h00;
                            o_busy       <= 1'b0;
                        end else begin
                            r_idx  <= w_next_idx;
                            o_data <= w_next_byte;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ch9350_led_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ch9350_led_tx
//  Purpose  : Scoreboard bench for ch9350_led_tx with directed stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ch9350_led_tx;

    localparam int unsigned c_REFRESH = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] leds = 3'b000;
    logic       update = 1'b0;
    logic       ready = 1'b1;
    logic       valid;
    logic [7:0] data;
    logic       busy;

    ch9350_led_tx #(
        .REFRESH_CYCLES (c_REFRESH),
        .HDR0           (8'h57),
        .HDR1           (8'hAB),
        .CMD            (8'h12)
    ) u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_leds       (leds),
        .i_update     (update),
        .i_data_ready (ready),
        .o_data_valid (valid),
        .o_data       (data),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    int         n_frames = 0;
    int         hdr_cyc = 0;
    int         prev_hdr_cyc = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] exp_byte;

    // Monitor: every byte handed over on valid&ready is popped and compared.
    always @(negedge clk) begin
        if (rst_n && prev_stall) begin
            checks++;
            if (!valid || data !== prev_data) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b data=%02h required valid=1 data=%02h",
                         valid, data, prev_data);
            end
        end
        prev_stall = rst_n && valid && !ready;
        prev_data  = data;
        if (rst_n && valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte: got %02h required no byte", data);
            end else begin
                exp_byte = exp_q.pop_front();
                if (data !== exp_byte) begin
                    errors++;
                    $display("FAIL frame_byte: got %02h required %02h", data, exp_byte);
                end
            end
            if (data == 8'h57) begin
                n_frames++;
                prev_hdr_cyc = hdr_cyc;
                hdr_cyc      = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_frame(input logic [2:0] l);
        logic [7:0] lv;
        lv = {5'b0, l};
        exp_q.push_back(8'h57);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'h12);
        exp_q.push_back(lv);
        exp_q.push_back(8'h12 + lv);
    endtask

    task automatic drain(input string name);
        int done;
        done = 0;
        for (int i = 0; i < 200 && done == 0; i++) begin
            if (exp_q.size() == 0 && !busy) done = 1;
            else tick();
        end
        chk(name, done, 1);
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        int i;
        i = 0;
        while (n_frames < target && i < budget) begin
            tick();
            i++;
        end
        chk(name, n_frames >= target ? 1 : 0, 1);
    endtask

    initial begin
        int n;
        int f;
        int u;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", data, 0);

        // Power-up frame, ready held high: 5 consecutive bytes
        push_frame(3'b000);
        rst_n = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy && n < 20);
        chk("frame1_len", n, 6);
        chk("frame1_valid_low", valid, 0);
        chk("frame1_q_empty", exp_q.size(), 0);

        // LED change sends exactly one frame
        repeat (5) tick();
        leds = 3'b010;
        push_frame(3'b010);
        drain("t2_drain");
        f = n_frames;
        repeat (40) tick();
        chk("t2_no_extra", n_frames, f);
        chk("t2_valid_low", valid, 0);

        // Back-pressure on the CMD byte
        ready = 1'b0;
        push_frame(3'b010);
        update = 1'b1;
        tick();
        update = 1'b0;
        chk("t3_hdr_valid", valid, 1);
        chk("t3_hdr_data", data, 8'h57);
        ready = 1'b1;
        tick();
        tick();
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_stall_data", data, 8'h12);
            chk("t3_stall_valid", valid, 1);
        end
        ready = 1'b1;
        drain("t3_drain");

        // LED change during a frame yields exactly one follow-up frame
        leds = 3'b001;
        push_frame(3'b001);
        push_frame(3'b111);
        tick();
        tick();
        leds = 3'b111;
        drain("t4_drain");
        chk("t4_gap", hdr_cyc - prev_hdr_cyc, 6);
        repeat (10) tick();
        chk("t4_no_third", exp_q.size() == 0 && !valid ? 1 : 0, 1);

        // Periodic refresh, then i_update restarts the period
        push_frame(3'b111);
        push_frame(3'b111);
        f = n_frames;
        wait_frames("t5_refresh_seen", f + 2, 400);
        chk("t5_period", hdr_cyc - prev_hdr_cyc, 105);
        drain("t5_drain1");
        repeat (20) tick();
        push_frame(3'b111);
        update = 1'b1;
        tick();
        u = cyc;
        update = 1'b0;
        drain("t5_drain2");
        chk("t5_update_now", hdr_cyc, u);
        push_frame(3'b111);
        f = n_frames;
        wait_frames("t5_restart_seen", f + 1, 200);
        chk("t5_restart_period", hdr_cyc - u, 105);
        drain("t5_drain3");

        // Asynchronous reset while byte 3 is on the bus
        f = n_frames;
        ready = 1'b0;
        push_frame(3'b111);
        update = 1'b1;
        tick();
        update = 1'b0;
        ready = 1'b1;
        repeat (3) tick();
        ready = 1'b0;
        chk("t6_byte3", data, 8'h07);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_data", data, 0);
        exp_q.delete();
        push_frame(3'b111);
        ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        drain("t6_drain");
        chk("t6_fresh_frame", n_frames, f + 2);

        chk("final_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
